// File: rtl/morse_tx_ctrl_pkg.sv
// Shared types and letter table for the Morse transmitter.
// Optional abort input is enabled by MORSE_ABORT_EN.
package morse_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] DOT_UNITS  = 2'd1;
  localparam logic [1:0] DASH_UNITS = 2'd3;
  localparam logic [1:0] GAP_UNITS  = 2'd1;

  // {len, pat}: pat LSB is sent first, 1 = dash
  function automatic logic [6:0] morse_lookup(
    input logic [2:0] letter
  );
    logic [6:0] r;
    r = 7'd0;
    unique case (letter)
      3'd0: r = {3'd2, 4'b0010};
      3'd1: r = {3'd4, 4'b0001};
      3'd2: r = {3'd4, 4'b0101};
      3'd3: r = {3'd3, 4'b0001};
      3'd4: r = {3'd1, 4'b0000};
      3'd5: r = {3'd4, 4'b0100};
      3'd6: r = {3'd3, 4'b0011};
      3'd7: r = {3'd4, 4'b0000};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_tx_ctrl_if.sv
// Control/status bundle between the board inputs and the sequencer.
// The abort signal exists only when MORSE_ABORT_EN is defined.
interface morse_tx_ctrl_if;

  logic       start;
  logic [2:0] letter;
  logic       led;
  logic       busy;
  logic       done;
`ifdef MORSE_ABORT_EN
  logic       abort;

  modport master (
    output start, letter, abort,
    input  led, busy, done
  );

  modport slave (
    input  start, letter, abort,
    output led, busy, done
  );
`else
  modport master (
    output start, letter,
    input  led, busy, done
  );

  modport slave (
    input  start, letter,
    output led, busy, done
  );
`endif

endinterface

// File: rtl/morse_tx_ctrl_timer.sv
// Unit timer: counts units*UNIT_CYCLES cycles and flags the last one.
// Holds at the limit rather than wrapping; clr restarts from zero.
module morse_unit_timer #(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic [1:0] units,
  output logic       expired
);

  localparam int unsigned TMR_W =
    $clog2(3 * UNIT_CYCLES + 1);

  logic [TMR_W-1:0] cnt;
  logic [TMR_W-1:0] limit;

  assign limit =
    TMR_W'(units) * TMR_W'(UNIT_CYCLES);

  assign expired = (cnt == limit - TMR_W'(1));

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/morse_tx_ctrl.sv
// Morse sequencer: letter A..H to timed dots, dashes and gaps on led.
// Define MORSE_ABORT_EN to add the abort input.
module morse_tx_ctrl
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 25_000_000
) (
  input logic             clk,
  input logic             reset,
  morse_tx_ctrl_if.slave  bus
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] pat;
  logic [2:0] len;
  logic       expired;
  logic       clr;
  logic [1:0] units;
  logic       kill;
  logic [6:0] lut;
  logic       led_d;
  logic       busy_d;
  logic       done_d;
  logic       led_q;
  logic       busy_q;
  logic       done_q;

`ifdef MORSE_ABORT_EN
  assign kill = bus.abort && (state != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  assign lut = morse_lookup(bus.letter);

  always_comb begin
    units = DOT_UNITS;
    unique case (1'b1)
      (state == S_GAP):  units = GAP_UNITS;
      (state == S_ON && pat[0]): units = DASH_UNITS;
      default: units = DOT_UNITS;
    endcase
  end

  assign clr = (state_nxt != state) ||
               (state == S_IDLE);

  morse_unit_timer #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (clr),
    .units  (units),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_ON;
      end
      S_ON: begin
        if (expired) begin
          state_nxt = (len > 3'd1) ? S_GAP : S_DONE;
        end
      end
      S_GAP: begin
        if (expired) state_nxt = S_ON;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_comb begin
    led_d  = (state_nxt == S_ON);
    busy_d = (state_nxt != S_IDLE);
    done_d = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Symbol shift happens as a gap hands over to the next symbol
  always_ff @(posedge clk) begin
    if (!reset) begin
      pat <= '0;
      len <= '0;
    end else if (state == S_IDLE && bus.start) begin
      pat <= lut[3:0];
      len <= lut[6:4];
    end else if (state == S_GAP &&
                 state_nxt == S_ON) begin
      pat <= pat >> 1;
      len <= len - 3'd1;
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_morse_tx_ctrl.sv
// Randomized bench for morse_tx_ctrl against a per-cycle waveform model.
// Build with +define+MORSE_ABORT_EN to exercise abort.
module tb_morse_tx_ctrl;

  localparam int U = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  morse_tx_ctrl_if bus ();

  morse_tx_ctrl #(
    .UNIT_CYCLES(U)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  // expected {led, busy, done} per cycle, front = now showing
  logic [2:0] q[$];
  string pats[8] = '{".-", "-...", "-.-.", "-..",
                     ".", "..-.", "--.", "...."};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d",
                  tag, got, exp);
  endtask

  task automatic build(input int l);
    string s;
    int n;
    s = pats[l];
    for (int i = 0; i < s.len(); i++) begin
      n = (s[i] == "-") ? 3 : 1;
      repeat (n * U) q.push_back(3'b110);
      if (i < s.len() - 1)
        repeat (U) q.push_back(3'b010);
    end
    q.push_back(3'b011);
  endtask

  function automatic logic abort_in();
`ifdef MORSE_ABORT_EN
    return bus.abort;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    logic [2:0] e;
    @(posedge clk);
    if (!reset) begin
      q.delete();
    end else if (abort_in() && q.size() > 0) begin
      q.delete();
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (bus.start) begin
      build(int'(bus.letter));
    end
    #1;
    e = (q.size() > 0) ? q[0] : 3'b000;
    chk("led", bus.led, e[2]);
    chk("busy", bus.busy, e[1]);
    chk("done", bus.done, e[0]);
  endtask

  task automatic send(input int l,
                      output int busy_n,
                      output int led_n);
    int g;
    bus.letter = 3'(l);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    busy_n = 0;
    led_n = 0;
    g = 0;
    while (bus.busy && g < 200) begin
      busy_n++;
      led_n += int'(bus.led);
      step();
      g++;
    end
    chk("send_timeout", 32'(g < 200), 1);
  endtask

  int bn, ln, dn;

  initial begin
    bus.start = 1'b0;
    bus.letter = 3'd0;
`ifdef MORSE_ABORT_EN
    bus.abort = 1'b0;
`endif
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (10) step();

    send(4, bn, ln);
    chk("E_led_cycles", bn == 0 ? 0 : ln, 4);
    chk("E_busy_cycles", bn, 5);

    send(0, bn, ln);
    chk("A_busy_cycles", bn, 21);
    chk("A_led_cycles", ln, 16);

    // H with a late A request that must be dropped
    bus.letter = 3'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    bus.letter = 3'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bn = 11;
    dn = 0;
    for (int i = 0; i < 60 && bus.busy; i++) begin
      dn += int'(bus.done);
      step();
      if (bus.busy) bn++;
    end
    chk("H_busy_cycles", bn, 29);
    repeat (5) step();

    // B reset in the middle of the second symbol
    bus.letter = 3'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (18) step();
    reset = 1'b0;
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b1;
    repeat (3) step();
    send(4, bn, ln);
    chk("E_after_rst", bn, 5);

`ifdef MORSE_ABORT_EN
    bus.letter = 3'd6;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (13) step();
    chk("G_in_gap", bus.led, 0);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    repeat (3) step();
    bus.letter = 3'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    reset = 1'b0;
    bus.abort = 1'b1;
    step();
    chk("abort_rst_led", bus.led, 0);
    reset = 1'b1;
    bus.abort = 1'b0;
    step();
`endif

    for (int i = 0; i < 3000; i++) begin
      bus.start = ($urandom_range(0, 7) == 0);
      bus.letter = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 299) != 0);
`ifdef MORSE_ABORT_EN
      bus.abort = ($urandom_range(0, 149) == 0);
`endif
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
